// File: rtl/pio_bank_pkg.sv
// Shared constants for the Avalon-MM PIO bank: bus width and word address map.
package pio_bank_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_DATA_IN  = 3'd0;
  localparam addr_t ADDR_EDGE     = 3'd1;
  localparam addr_t ADDR_MASK     = 3'd2;
  localparam addr_t ADDR_OUT_BASE = 3'd4;

  // Word address of output register k.
  function automatic addr_t out_addr(input int k);
    return ADDR_OUT_BASE + addr_t'(k);
  endfunction

endpackage

// File: rtl/pio_input_cond.sv
// One input bit: 2-flop synchroniser feeding a conditioned-value register.
// With PIO_BANK_DEBOUNCE_EN the register only follows after DEB_CYC stable cycles.
module pio_input_cond #(
  parameter int DEB_CYC = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic cond_o
);

  logic sync1_q;
  logic sync2_q;
  logic cond_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYC);

  logic [CNT_W-1:0] cnt_q;

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      cond_q <= 1'b0;
    end else if (sync2_q == cond_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
      cnt_q  <= '0;
      cond_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  localparam int unused_deb_cyc = DEB_CYC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= 1'b0;
    end else begin
      cond_q <= sync2_q;
    end
  end
`endif

  assign cond_o = cond_q;

endmodule

// File: rtl/pio_bank_avmm.sv
// Avalon-MM PIO bank: N_OUT output registers, conditioned inputs with edge capture
// and maskable level irq. Optional input debounce under PIO_BANK_DEBOUNCE_EN.
module pio_bank_avmm
  import pio_bank_pkg::*;
#(
  parameter int          IN_W    = 8,
  parameter int          OUT_W   = 16,
  parameter int          N_OUT   = 4,
  parameter logic [31:0] OUT_RST = 32'h0,
  parameter int          DEB_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             address,
  input  logic                   read,
  output logic [31:0]            readdata,
  input  logic                   write,
  input  logic [31:0]            writedata,
  input  logic [IN_W-1:0]        pins_in,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic                   irq
);

  logic [IN_W-1:0]  cond;
  logic [IN_W-1:0]  prev_q;
  logic [IN_W-1:0]  rise;
  logic [IN_W-1:0]  edge_q;
  logic [IN_W-1:0]  edge_d;
  logic [IN_W-1:0]  mask_q;
  logic [OUT_W-1:0] out_q [N_OUT];
  word_t            readdata_q;
  word_t            readdata_d;
  logic             irq_q;
  logic             wr_edge;
  logic             wr_mask;
  logic             unused_wd;

  for (genvar gi = 0; gi < IN_W; gi++) begin : g_in
    pio_input_cond #(
      .DEB_CYC(DEB_CYC)
    ) u_cond (
      .clk    (clk),
      .reset_n(reset_n),
      .pin_i  (pins_in[gi]),
      .cond_o (cond[gi])
    );
  end

  assign rise    = cond & ~prev_q;
  assign wr_edge = write && (address == ADDR_EDGE);
  assign wr_mask = write && (address == ADDR_MASK);

  // New edges are OR-ed in after the clear so a simultaneous set wins.
  always_comb begin
    edge_d = edge_q;
    if (wr_edge) begin
      edge_d = edge_q & ~writedata[IN_W-1:0];
    end
    edge_d = edge_d | rise;
  end

  // Read mux sees current register state, so a same-cycle write is not visible.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA_IN: readdata_d = word_t'(cond);
      ADDR_EDGE:    readdata_d = word_t'(edge_q);
      ADDR_MASK:    readdata_d = word_t'(mask_q);
      default:      readdata_d = '0;
    endcase
    for (int k = 0; k < N_OUT; k++) begin
      if (address == out_addr(k)) begin
        readdata_d = word_t'(out_q[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= OUT_RST[OUT_W-1:0];
      end
    end else begin
      prev_q <= cond;
      edge_q <= edge_d;
      irq_q  <= |(edge_q & mask_q);
      if (wr_mask) begin
        mask_q <= writedata[IN_W-1:0];
      end
      if (read) begin
        readdata_q <= readdata_d;
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (write && (address == out_addr(k))) begin
          out_q[k] <= writedata[OUT_W-1:0];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out_data[gi*OUT_W +: OUT_W] = out_q[gi];
  end

  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign unused_wd = &{1'b0, writedata};

endmodule

// File: tb/tb_pio_bank_avmm.sv
// Self-checking bench for pio_bank_avmm; builds with or without PIO_BANK_DEBOUNCE_EN.
module tb_pio_bank_avmm;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 16;
  localparam int N_OUT   = 4;
  localparam int DEB_CYC = 8;
`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int COND_LAT = 2 + DEB_CYC;
`else
  localparam int COND_LAT = 3;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [2:0]             address;
  logic                   read;
  logic [31:0]            readdata;
  logic                   write;
  logic [31:0]            writedata;
  logic [IN_W-1:0]        pins_in;
  logic [N_OUT*OUT_W-1:0] out_data;
  logic                   irq;

  int total = 0;
  int bad   = 0;

  logic [OUT_W-1:0] m_out [N_OUT];
  logic [IN_W-1:0]  m_edge;
  logic [IN_W-1:0]  m_mask;

  always #5 clk = ~clk;

  pio_bank_avmm #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .N_OUT  (N_OUT),
    .OUT_RST(32'h0),
    .DEB_CYC(DEB_CYC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .read     (read),
    .readdata (readdata),
    .write    (write),
    .writedata(writedata),
    .pins_in  (pins_in),
    .out_data (out_data),
    .irq      (irq)
  );

  function automatic logic [N_OUT*OUT_W-1:0] exp_out_data();
    logic [N_OUT*OUT_W-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k*OUT_W +: OUT_W] = m_out[k];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {{(32-IN_W){1'b0}}, pins_in};
    if (ai == 1) return {{(32-IN_W){1'b0}}, m_edge};
    if (ai == 2) return {{(32-IN_W){1'b0}}, m_mask};
    if (ai >= 4 && ai < 4 + N_OUT) return {{(32-OUT_W){1'b0}}, m_out[ai-4]};
    return 32'h0;
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    int ai;
    ai = int'(a);
    if (ai == 1) m_edge = m_edge & ~d[IN_W-1:0];
    else if (ai == 2) m_mask = d[IN_W-1:0];
    else if (ai >= 4 && ai < 4 + N_OUT) m_out[ai-4] = d[OUT_W-1:0];
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    $display("wr addr=%0d data=%08h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
    $display("rd addr=%0d data=%08h", a, d);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0; pins_in = '0;
    repeat (3) @(negedge clk);
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", out_data); end
    total++; if (readdata !== '0) begin bad++; $display("FAIL reset_rd: got %h want 0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    @(negedge clk);
    bus_write(3'd4, 32'h0000_5A5A);
    bus_read(3'd4, d);
    total++; if (d !== 32'h5A5A) begin bad++; $display("FAIL pre_reset_rd: got %h want 00005a5a", d); end
    // Write and read in flight when reset hits.
    address = 3'd4; writedata = 32'h1234; write = 1'b1; read = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    total++; if (out_data !== '0) begin bad++; $display("FAIL midrst_out: got %h want 0", out_data); end
    total++; if (readdata !== '0) begin bad++; $display("FAIL midrst_rd: got %h want 0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midrst_irq: got %b want 0", irq); end
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    #1 reset_n = 1'b1;
    @(negedge clk);
    total++; if (out_data !== '0) begin bad++; $display("FAIL postrst_out: got %h want 0", out_data); end
    total++; if (readdata !== '0) begin bad++; $display("FAIL postrst_rd: got %h want 0", readdata); end
    bus_read(3'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL lost_write: got %h want 0", d); end
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    m_edge = '0; m_mask = '0;
  endtask

  task automatic test_out_regs();
    logic [31:0] d;
    bus_write(3'd5, 32'hDEAD_BEEF); model_write(3'd5, 32'hDEAD_BEEF);
    total++; if (out_data[31:16] !== 16'hBEEF) begin bad++; $display("FAIL out1_slice: got %h want beef", out_data[31:16]); end
    total++; if (out_data !== exp_out_data()) begin bad++; $display("FAIL out_bus: got %h want %h", out_data, exp_out_data()); end
    bus_read(3'd5, d);
    total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL rd_out1: got %h want 0000beef", d); end
    @(negedge clk);
    total++; if (readdata !== 32'h0000_BEEF) begin bad++; $display("FAIL rd_hold: got %h want 0000beef", readdata); end
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read(3'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_reserved: got %h want 0", d); end
    for (int a = 4; a < 8; a++) begin
      d = $urandom;
      bus_write(3'(a), d); model_write(3'(a), d);
    end
    for (int a = 4; a < 8; a++) begin
      bus_read(3'(a), d);
      total++; if (d !== model_read(3'(a))) begin bad++; $display("FAIL rd_out%0d: got %h want %h", a - 4, d, model_read(3'(a))); end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] d, old_v, new_v;
    old_v = model_read(3'd6);
    new_v = $urandom;
    address = 3'd6; writedata = new_v; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    model_write(3'd6, new_v);
    total++; if (readdata !== old_v) begin bad++; $display("FAIL rw_same_old: got %h want %h", readdata, old_v); end
    bus_read(3'd6, d);
    total++; if (d !== model_read(3'd6)) begin bad++; $display("FAIL rw_same_new: got %h want %h", d, model_read(3'd6)); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic exp_bit;
    bus_write(3'd2, 32'h01); model_write(3'd2, 32'h01);
    pins_in[0] = 1'b1;
    address = 3'd1; read = 1'b1;
    // Cap sets on edge COND_LAT+1; readdata shows it and irq rises one edge later.
    for (int k = 1; k <= COND_LAT + 3; k++) begin
      @(negedge clk);
      exp_bit = (k >= COND_LAT + 2);
      total++; if (readdata !== {31'h0, exp_bit}) begin bad++; $display("FAIL cap_timing k=%0d: got %h want %h", k, readdata, {31'h0, exp_bit}); end
      total++; if (irq !== exp_bit) begin bad++; $display("FAIL irq_timing k=%0d: got %b want %b", k, irq, exp_bit); end
    end
    read = 1'b0;
    m_edge[0] = 1'b1;
    bus_write(3'd1, 32'h01); model_write(3'd1, 32'h01);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_read(3'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cap_clear: got %h want 0", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    pins_in[6] = 1'b1;
    repeat (COND_LAT + 2) @(negedge clk);
    m_edge[6] = 1'b1;
    pins_in[2] = 1'b1;
    repeat (COND_LAT) @(negedge clk);
    bus_write(3'd1, 32'h44);
    m_edge = (m_edge & ~8'h44) | 8'h04;
    bus_read(3'd1, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL w1c_collision: got %h want 00000004", d); end
    bus_write(3'd1, 32'hFF); model_write(3'd1, 32'hFF);
  endtask

  task automatic test_masking();
    logic [31:0] d;
    bus_write(3'd2, 32'h0); model_write(3'd2, 32'h0);
    pins_in[1] = 1'b1; pins_in[3] = 1'b1;
    for (int k = 0; k < COND_LAT + 2; k++) begin
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL masked_irq k=%0d: got %b want 0", k, irq); end
    end
    m_edge = m_edge | 8'h0A;
    bus_read(3'd1, d);
    total++; if (d !== 32'h0A) begin bad++; $display("FAIL masked_cap: got %h want 0000000a", d); end
    bus_write(3'd2, 32'h08); model_write(3'd2, 32'h08);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq: got %b want 1", irq); end
    bus_write(3'd1, 32'hFF); model_write(3'd1, 32'hFF);
    bus_write(3'd2, 32'h0); model_write(3'd2, 32'h0);
  endtask

`ifdef PIO_BANK_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d;
    logic exp_bit;
    pins_in[0] = 1'b0;
    repeat (COND_LAT + 4) @(negedge clk);
    bus_write(3'd1, 32'hFF); model_write(3'd1, 32'hFF);
    // 5-cycle glitch must never reach DATA_IN.
    pins_in[0] = 1'b1;
    address = 3'd0; read = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 5) pins_in[0] = 1'b0;
      total++; if (readdata[0] !== 1'b0) begin bad++; $display("FAIL glitch k=%0d: got %b want 0", k, readdata[0]); end
    end
    read = 1'b0;
    bus_read(3'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_cap: got %h want 0", d); end
    pins_in[0] = 1'b1;
    address = 3'd0; read = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 10) pins_in[0] = 1'b0;
      exp_bit = (k >= COND_LAT + 1);
      total++; if (readdata[0] !== exp_bit) begin bad++; $display("FAIL pulse k=%0d: got %b want %b", k, readdata[0], exp_bit); end
    end
    read = 1'b0;
    bus_read(3'd1, d);
    total++; if (d !== 32'h01) begin bad++; $display("FAIL pulse_cap: got %h want 00000001", d); end
    repeat (3 * DEB_CYC) @(negedge clk);
    bus_write(3'd1, 32'hFF); model_write(3'd1, 32'hFF);
  endtask
`endif

  task automatic test_random();
    logic [31:0] d, wd;
    logic [2:0] a;
    logic [IN_W-1:0] old_p, new_p;
    int op;
    for (int a4 = 4; a4 < 8; a4++) begin
      wd = $urandom; bus_write(3'(a4), wd); model_write(3'(a4), wd);
    end
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      a  = 3'($urandom_range(0, 7));
      if (op == 0) begin
        old_p = pins_in;
        new_p = IN_W'($urandom);
        pins_in = new_p;
        repeat (COND_LAT + 2) @(negedge clk);
        m_edge = m_edge | (new_p & ~old_p);
        $display("pins %02h -> %02h", old_p, new_p);
      end else if (op <= 5) begin
        wd = $urandom;
        if ($urandom_range(0, 1) == 1) wd = wd & 32'h0000_00FF;
        bus_write(a, wd); model_write(a, wd);
        total++; if (out_data !== exp_out_data()) begin bad++; $display("FAIL rnd_out i=%0d: got %h want %h", i, out_data, exp_out_data()); end
      end else begin
        bus_read(a, d);
        total++; if (d !== model_read(a)) begin bad++; $display("FAIL rnd_rd i=%0d addr=%0d: got %h want %h", i, a, d, model_read(a)); end
        total++; if (irq !== (|(m_edge & m_mask))) begin bad++; $display("FAIL rnd_irq i=%0d: got %b want %b", i, irq, |(m_edge & m_mask)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_out_regs();
    test_rw_same();
    test_edge_irq();
    test_w1c_collision();
    test_masking();
`ifdef PIO_BANK_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
